// File: rtl/sw_debounce.sv
// Switch input stage: 2-flop synchroniser and per-channel stability-counter
// debouncer, producing clean levels, edge pulses and a one-hot press code.
module sw_debounce #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] code,
    output logic             multi
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE0,
        CHK1,
        STABLE1,
        CHK0
    } db_state_e;

    logic [WIDTH-1:0] sync1, sync2;

    db_state_e [WIDTH-1:0]            state, state_nxt;
    logic      [WIDTH-1:0][CNT_W-1:0] cnt, cnt_nxt;
    logic      [WIDTH-1:0]            clean_nxt, rise_nxt, fall_nxt;

    logic [WIDTH-1:0] code_nxt;
    logic             multi_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            state    <= {WIDTH{STABLE0}};
            cnt      <= '0;
            sw_clean <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
            code     <= '0;
            multi    <= 1'b0;
        end else begin
            sync1    <= sw_raw;
            sync2    <= sync1;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sw_clean <= clean_nxt;
            sw_rise  <= rise_nxt;
            sw_fall  <= fall_nxt;
            code     <= code_nxt;
            multi    <= multi_nxt;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clean_nxt = sw_clean;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (state[i])
                STABLE0: begin
                    if (sync2[i]) begin
                        state_nxt[i] = CHK1;
                        cnt_nxt[i]   = '0;
                    end
                end
                CHK1: begin
                    if (!sync2[i]) begin
                        state_nxt[i] = STABLE0;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = STABLE1;
                        clean_nxt[i] = 1'b1;
                        rise_nxt[i]  = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                STABLE1: begin
                    if (!sync2[i]) begin
                        state_nxt[i] = CHK0;
                        cnt_nxt[i]   = '0;
                    end
                end
                CHK0: begin
                    if (sync2[i]) begin
                        state_nxt[i] = STABLE1;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = STABLE0;
                        clean_nxt[i] = 1'b0;
                        fall_nxt[i]  = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt[i] = STABLE0;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Clearing the lowest set bit leaves a non-zero value only when two or
    // more switches are down.
    always_comb begin
        multi_nxt = |(sw_clean & (sw_clean - WIDTH'(1)));
        code_nxt  = multi_nxt ? '0 : sw_clean;
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (DB_CYCLES=4): stimulus pushes expected
// edge and code events; a negedge monitor pops them as the DUT reports them.
module tb_sw_debounce;

    localparam int W  = 4;
    localparam int DB = 4;

    typedef struct {
        int           cyc;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] clean;
    } edge_t;

    typedef struct {
        int           cyc;
        logic [W-1:0] code;
        logic         multi;
    } code_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean, sw_rise, sw_fall, code;
    logic         multi;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    edge_t edge_q[$];
    code_t code_q[$];

    logic [W-1:0] prev_code  = '0;
    logic         prev_multi = 1'b0;

    sw_debounce #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw),
        .sw_clean(sw_clean),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .code    (code),
        .multi   (multi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_edge(input int c, input logic [W-1:0] r, input logic [W-1:0] f,
                            input logic [W-1:0] cl);
        edge_t e;
        e.cyc = c; e.rise = r; e.fall = f; e.clean = cl;
        edge_q.push_back(e);
    endtask

    task automatic exp_code(input int c, input logic [W-1:0] cd, input logic m);
        code_t e;
        e.cyc = c; e.code = cd; e.multi = m;
        code_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clean"}, 32'(sw_clean), 32'd0);
        check({tag, "_rise"},  32'(sw_rise),  32'd0);
        check({tag, "_fall"},  32'(sw_fall),  32'd0);
        check({tag, "_code"},  32'(code),     32'd0);
        check({tag, "_multi"}, 32'(multi),    32'd0);
    endtask

    // Monitor: any edge pulse or code/multi change is a DUT output event.
    always @(negedge clk) begin
        if (!rst) begin
            prev_code  = '0;
            prev_multi = 1'b0;
        end else begin
            if ((sw_rise | sw_fall) != '0) begin
                if (edge_q.size() == 0) begin
                    check("unexpected_edge", {24'd0, sw_rise, sw_fall}, 32'd0);
                end else begin
                    edge_t e;
                    e = edge_q.pop_front();
                    check("edge_cycle", 32'(cyc), 32'(e.cyc));
                    check("edge_rise",  32'(sw_rise),  32'(e.rise));
                    check("edge_fall",  32'(sw_fall),  32'(e.fall));
                    check("edge_clean", 32'(sw_clean), 32'(e.clean));
                end
            end
            if (code != prev_code || multi != prev_multi) begin
                if (code_q.size() == 0) begin
                    check("unexpected_code", {27'd0, multi, code}, {27'd0, prev_multi, prev_code});
                end else begin
                    code_t e;
                    e = code_q.pop_front();
                    check("code_cycle", 32'(cyc),   32'(e.cyc));
                    check("code_value", 32'(code),  32'(e.code));
                    check("code_multi", 32'(multi), 32'(e.multi));
                end
                prev_code  = code;
                prev_multi = multi;
            end
        end
    end

    initial begin
        int c;
        rst    = 1'b1;
        sw_raw = '0;
        #2 rst = 1'b0;
        #1 check_all_zero("reset");
        idle(3);
        rst = 1'b1;
        idle(2);

        // Single press: clean after 7 edges, code one edge later.
        c = cyc; sw_raw = 4'b0001;
        exp_edge(c + 7, 4'b0001, 4'b0000, 4'b0001);
        exp_code(c + 8, 4'b0001, 1'b0);
        idle(12);

        // Bouncing bit 1: only the last stable stretch counts.
        c = cyc; sw_raw = 4'b0011;
        idle(2); sw_raw = 4'b0001;
        idle(2); sw_raw = 4'b0011;
        exp_edge(c + 11, 4'b0010, 4'b0000, 4'b0011);
        exp_code(c + 12, 4'b0000, 1'b1);
        idle(14);

        c = cyc; sw_raw = 4'b0001;
        exp_edge(c + 7, 4'b0000, 4'b0010, 4'b0001);
        exp_code(c + 8, 4'b0001, 1'b0);
        idle(12);

        c = cyc; sw_raw = 4'b0000;
        exp_edge(c + 7, 4'b0000, 4'b0001, 4'b0000);
        exp_code(c + 8, 4'b0000, 1'b0);
        idle(12);

        // Glitch shorter than the debounce window: no events at all.
        sw_raw = 4'b0001;
        idle(3); sw_raw = 4'b0000;
        idle(12);

        // Two switches together: simultaneous pulses, multi forces code to 0.
        c = cyc; sw_raw = 4'b0101;
        exp_edge(c + 7, 4'b0101, 4'b0000, 4'b0101);
        exp_code(c + 8, 4'b0000, 1'b1);
        idle(12);

        c = cyc; sw_raw = 4'b0000;
        exp_edge(c + 7, 4'b0000, 4'b0101, 4'b0000);
        exp_code(c + 8, 4'b0000, 1'b0);
        idle(12);

        // Reset while bit 2 is mid-check and bit 0 is settled high.
        c = cyc; sw_raw = 4'b0001;
        exp_edge(c + 7, 4'b0001, 4'b0000, 4'b0001);
        exp_code(c + 8, 4'b0001, 1'b0);
        idle(12);

        sw_raw = 4'b0101;
        idle(4);
        rst = 1'b0;
        #1 check_all_zero("midreset");
        idle(3);
        c = cyc; rst = 1'b1;
        exp_edge(c + 7, 4'b0101, 4'b0000, 4'b0101);
        exp_code(c + 8, 4'b0000, 1'b1);
        idle(12);

        c = cyc; sw_raw = 4'b0000;
        exp_edge(c + 7, 4'b0000, 4'b0101, 4'b0000);
        exp_code(c + 8, 4'b0000, 1'b0);
        idle(12);

        check("edge_queue_drained", 32'(edge_q.size()), 32'd0);
        check("code_queue_drained", 32'(code_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
